// File: rtl/idc_param.sv
// Parametrised image-display controller: loads an image and an opcode list, edits a
// movable 2x2 window, then streams a subsampled or zoomed OUT_DIM x OUT_DIM view.
module idc_param #(
    parameter int DATA_W  = 7,
    parameter int IMG_DIM = 8,
    parameter int OP_NUM  = 15,
    parameter int OUT_DIM = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic                     cg_en,
    input  logic signed [DATA_W-1:0] in_data,
    input  logic [3:0]               op,
    output logic                     out_valid,
    output logic signed [DATA_W-1:0] out_data
);

    localparam int PIX_NUM  = IMG_DIM * IMG_DIM;
    localparam int VIEW_NUM = OUT_DIM * OUT_DIM;
    localparam int PW       = $clog2(IMG_DIM);
    localparam int AW       = 2 * PW;
    localparam int CNT_W    = $clog2(PIX_NUM + 1);
    localparam int OPI_W    = $clog2(OP_NUM + 1);
    localparam int OW       = $clog2(OUT_DIM);
    localparam int SUB_SH   = $clog2(IMG_DIM / OUT_DIM);

    localparam logic signed [DATA_W-1:0] PIX_MIN = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] PIX_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [PW-1:0] PTR_INIT = PW'(IMG_DIM / 2 - 1);
    localparam logic [PW-1:0] PTR_EDGE = PW'(IMG_DIM - 2);
    localparam logic [PW:0]   VIEW_LIM = (PW + 1)'(IMG_DIM - OUT_DIM);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_EXEC, S_OUT} state_t;

    typedef enum logic [3:0] {
        OP_MED, OP_AVG, OP_ROT_CCW, OP_ROT_CW, OP_FLIP,
        OP_UP, OP_LEFT, OP_DOWN, OP_RIGHT, OP_ZOOM_IN, OP_ZOOM_OUT
    } op_t;

    state_t                   state;
    logic [CNT_W-1:0]         cnt;
    logic [PW-1:0]            ptr_r, ptr_c;
    logic                     zoom;

    logic signed [DATA_W-1:0] img    [PIX_NUM];
    logic [3:0]               op_mem [OP_NUM];

    logic                     pix_we, op_we, last_pix, exec_en, store_en;
    logic [AW-1:0]            pix_addr;
    logic [3:0]               cur_op;

    logic [PW-1:0]            r1, c1;
    logic [AW-1:0]            a_tl, a_tr, a_bl, a_br;
    logic signed [DATA_W-1:0] v_tl, v_tr, v_bl, v_br;
    logic signed [DATA_W-1:0] lo01, hi01, lo23, hi23, mn, mx;
    logic signed [DATA_W+1:0] sum4, mid, med_full, avg_full;
    logic signed [DATA_W-1:0] med_v, avg_v;

    logic [OW-1:0]            vi, vj;
    logic [PW:0]              r_inc, c_inc, r0, c0;
    logic [PW-1:0]            vr, vc;
    logic [AW-1:0]            view_addr;

    function automatic logic signed [DATA_W+1:0] ext(input logic signed [DATA_W-1:0] x);
        return {{2{x[DATA_W-1]}}, x};
    endfunction

    function automatic logic signed [DATA_W-1:0] sat_neg(input logic signed [DATA_W-1:0] x);
        return (x == PIX_MIN) ? PIX_MAX : -x;
    endfunction

    // NOTE: every always_comb output gets a value on every path, so no latches are inferred.
    always_comb begin
        pix_we   = (state == S_IDLE && in_valid) || state == S_LOAD;
        pix_addr = (state == S_LOAD) ? cnt[AW-1:0] : '0;
        op_we    = pix_we && (int'(pix_addr) < OP_NUM);
        last_pix = (state == S_LOAD) && (cnt == CNT_W'(PIX_NUM - 1));
        // Op 0 runs on the last load edge so the final op settles one cycle before output starts.
        exec_en  = last_pix || state == S_EXEC;
        cur_op   = (state == S_EXEC) ? op_mem[OPI_W'(cnt)] : op_mem[0];
        store_en = !cg_en || pix_we || exec_en;
    end

    always_comb begin
        r1   = ptr_r + 1'b1;
        c1   = ptr_c + 1'b1;
        a_tl = {ptr_r, ptr_c};
        a_tr = {ptr_r, c1};
        a_bl = {r1, ptr_c};
        a_br = {r1, c1};
        v_tl = img[a_tl];
        v_tr = img[a_tr];
        v_bl = img[a_bl];
        v_br = img[a_br];

        lo01 = (v_tl < v_tr) ? v_tl : v_tr;
        hi01 = (v_tl < v_tr) ? v_tr : v_tl;
        lo23 = (v_bl < v_br) ? v_bl : v_br;
        hi23 = (v_bl < v_br) ? v_br : v_bl;
        mn   = (lo01 < lo23) ? lo01 : lo23;
        mx   = (hi01 > hi23) ? hi01 : hi23;

        // The two middle values of the sorted four are the total minus the extremes.
        sum4     = ext(v_tl) + ext(v_tr) + ext(v_bl) + ext(v_br);
        mid      = sum4 - ext(mn) - ext(mx);
        med_full = mid >>> 1;
        avg_full = sum4 >>> 2;
        med_v    = med_full[DATA_W-1:0];
        avg_v    = avg_full[DATA_W-1:0];
    end

    always_comb begin
        vi    = cnt[2*OW-1:OW];
        vj    = cnt[OW-1:0];
        r_inc = {1'b0, ptr_r} + 1'b1;
        c_inc = {1'b0, ptr_c} + 1'b1;
        r0    = (r_inc > VIEW_LIM) ? VIEW_LIM : r_inc;
        c0    = (c_inc > VIEW_LIM) ? VIEW_LIM : c_inc;
        if (zoom) begin
            vr = r0[PW-1:0] + PW'(vi);
            vc = c0[PW-1:0] + PW'(vj);
        end else begin
            vr = PW'(vi) << SUB_SH;
            vc = PW'(vj) << SUB_SH;
        end
        view_addr = {vr, vc};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            ptr_r     <= PTR_INIT;
            ptr_c     <= PTR_INIT;
            zoom      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= 1'b0;
            out_data  <= '0;
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        state <= S_LOAD;
                        cnt   <= CNT_W'(1);
                        ptr_r <= PTR_INIT;
                        ptr_c <= PTR_INIT;
                        zoom  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (last_pix) begin
                        if (OP_NUM == 1) begin
                            state <= S_OUT;
                            cnt   <= '0;
                        end else begin
                            state <= S_EXEC;
                            cnt   <= CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_EXEC: begin
                    if (cnt == CNT_W'(OP_NUM - 1)) begin
                        state <= S_OUT;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_OUT: begin
                    // One trailing cycle keeps in_valid ignored until the last pixel has been shown.
                    if (cnt == CNT_W'(VIEW_NUM)) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= img[view_addr];
                        cnt       <= cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (exec_en) begin
                case (cur_op)
                    OP_UP:       if (ptr_r != '0)       ptr_r <= ptr_r - 1'b1;
                    OP_LEFT:     if (ptr_c != '0)       ptr_c <= ptr_c - 1'b1;
                    OP_DOWN:     if (ptr_r != PTR_EDGE) ptr_r <= ptr_r + 1'b1;
                    OP_RIGHT:    if (ptr_c != PTR_EDGE) ptr_c <= ptr_c + 1'b1;
                    OP_ZOOM_IN:  zoom <= 1'b1;
                    OP_ZOOM_OUT: zoom <= 1'b0;
                    default:     ;
                endcase
            end
        end
    end

    // NOTE: image and opcode storage carry no reset; every entry is rewritten before it is read.
    always_ff @(posedge clk) begin
        if (store_en) begin
            if (pix_we) img[pix_addr] <= in_data;
            if (op_we)  op_mem[OPI_W'(pix_addr)] <= op;
            if (exec_en) begin
                case (cur_op)
                    OP_MED: begin
                        img[a_tl] <= med_v;
                        img[a_tr] <= med_v;
                        img[a_bl] <= med_v;
                        img[a_br] <= med_v;
                    end
                    OP_AVG: begin
                        img[a_tl] <= avg_v;
                        img[a_tr] <= avg_v;
                        img[a_bl] <= avg_v;
                        img[a_br] <= avg_v;
                    end
                    OP_ROT_CCW: begin
                        img[a_tl] <= v_tr;
                        img[a_tr] <= v_br;
                        img[a_br] <= v_bl;
                        img[a_bl] <= v_tl;
                    end
                    OP_ROT_CW: begin
                        img[a_tl] <= v_bl;
                        img[a_tr] <= v_tl;
                        img[a_br] <= v_tr;
                        img[a_bl] <= v_br;
                    end
                    OP_FLIP: begin
                        img[a_tl] <= sat_neg(v_tl);
                        img[a_tr] <= sat_neg(v_tr);
                        img[a_bl] <= sat_neg(v_bl);
                        img[a_br] <= sat_neg(v_br);
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_idc_param.sv
// Self-checking bench for idc_param: directed frames plus random frames, every output
// cycle compared against a behavioural model of the controller.
module tb_idc_param;

    localparam int DW  = 7;
    localparam int ID  = 8;
    localparam int OPN = 15;
    localparam int OD  = 4;
    localparam int PIX = ID * ID;
    localparam int VN  = OD * OD;

    typedef int img_t  [PIX];
    typedef int ops_t  [OPN];
    typedef int view_t [VN];

    logic                 clk = 1'b0;
    logic                 rst, in_valid, cg_en, out_valid;
    logic signed [DW-1:0] in_data, out_data;
    logic [3:0]           op;

    int cyc    = 0;
    int checks = 0;
    int errors = 0;
    bit cmp_on = 1'b0;
    int exp_map [int];

    idc_param #(.DATA_W(DW), .IMG_DIM(ID), .OP_NUM(OPN), .OUT_DIM(OD)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .cg_en    (cg_en),
        .in_data  (in_data),
        .op       (op),
        .out_valid(out_valid),
        .out_data (out_data)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, req);
        end
    endtask

    // Cycle-by-cycle compare: outputs are sampled mid-cycle on the falling edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            int ev, ed;
            if (exp_map.exists(cyc)) begin
                ev = 1;
                ed = exp_map[cyc];
            end else begin
                ev = 0;
                ed = 0;
            end
            check("out_valid", int'(out_valid), ev);
            check("out_data", int'(out_data), ed);
        end
    end

    function automatic int floor_div(input int a, input int b);
        int q = a / b;
        if ((a % b) != 0 && ((a < 0) != (b < 0))) q--;
        return q;
    endfunction

    task automatic model(input img_t pix, input ops_t ops, output view_t v);
        int im [ID][ID];
        int w [4];
        int s [4];
        int r, c, zoom, val, tmp, r0, c0;
        int lo = -(2 ** (DW - 1));
        int hi = 2 ** (DW - 1) - 1;
        for (int p = 0; p < PIX; p++) im[p / ID][p % ID] = pix[p];
        r = ID / 2 - 1;
        c = ID / 2 - 1;
        zoom = 0;
        for (int k = 0; k < OPN; k++) begin
            w[0] = im[r][c];
            w[1] = im[r][c+1];
            w[2] = im[r+1][c];
            w[3] = im[r+1][c+1];
            s = w;
            case (ops[k])
                0: begin
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3 - i; j++)
                            if (s[j] > s[j+1]) begin
                                tmp = s[j]; s[j] = s[j+1]; s[j+1] = tmp;
                            end
                    val = floor_div(s[1] + s[2], 2);
                    w = '{val, val, val, val};
                end
                1: begin
                    val = floor_div(s[0] + s[1] + s[2] + s[3], 4);
                    w = '{val, val, val, val};
                end
                2: w = '{s[1], s[3], s[0], s[2]};
                3: w = '{s[2], s[0], s[3], s[1]};
                4: for (int i = 0; i < 4; i++) w[i] = (s[i] == lo) ? hi : -s[i];
                5: if (r > 0) r--;
                6: if (c > 0) c--;
                7: if (r < ID - 2) r++;
                8: if (c < ID - 2) c++;
                9: zoom = 1;
                10: zoom = 0;
                default: ;
            endcase
            if (ops[k] <= 4) begin
                im[r][c]     = w[0];
                im[r][c+1]   = w[1];
                im[r+1][c]   = w[2];
                im[r+1][c+1] = w[3];
            end
        end
        r0 = (r + 1 < ID - OD) ? r + 1 : ID - OD;
        c0 = (c + 1 < ID - OD) ? c + 1 : ID - OD;
        for (int i = 0; i < OD; i++)
            for (int j = 0; j < OD; j++)
                v[i*OD + j] = zoom ? im[r0+i][c0+j] : im[i*(ID/OD)][j*(ID/OD)];
    endtask

    task automatic run_frame(input img_t pix, input ops_t ops, input bit cg,
                             input bit noise, input bit do_rst);
        view_t v;
        int    last;
        model(pix, ops, v);
        @(posedge clk); #1;
        last = cyc + PIX - 1;
        if (!do_rst)
            for (int k = 0; k < VN; k++) exp_map[last + OPN + 1 + k] = v[k];
        cg_en = cg;
        for (int p = 0; p < PIX; p++) begin
            in_valid = 1'b1;
            in_data  = DW'(pix[p]);
            op       = (p < OPN) ? 4'(ops[p]) : 4'($urandom);
            @(posedge clk); #1;
        end
        for (int t = 1; t <= OPN + VN; t++) begin
            in_valid = noise ? 1'($urandom) : 1'b0;
            in_data  = DW'($urandom);
            op       = 4'($urandom);
            rst      = do_rst && (t == 5);
            @(posedge clk); #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(posedge clk);
    endtask

    img_t  ramp, neg, rimg;
    ops_t  o_nop, o_avg, o_cw, o_flip, o_up, rops;
    view_t mv;
    int    exp1 [VN];

    initial begin
        rst = 1'b1; in_valid = 1'b0; cg_en = 1'b0; in_data = '0; op = '0;
        @(posedge clk); #1;
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        for (int p = 0; p < PIX; p++) begin
            ramp[p] = p;
            neg[p]  = -64;
        end
        for (int k = 0; k < OPN; k++) begin
            o_nop[k] = 11; o_avg[k] = 11; o_cw[k] = 11; o_flip[k] = 11; o_up[k] = 11;
        end
        o_avg[0] = 1; o_avg[1] = 9;
        o_cw[0] = 3;  o_cw[1] = 9;
        o_flip[0] = 4; o_flip[1] = 9;
        for (int k = 0; k < 8; k++) o_up[k] = 5;
        o_up[8] = 9;

        // Hand-computed values that pin the model itself.
        exp1 = '{0, 2, 4, 6, 16, 18, 20, 22, 32, 34, 36, 38, 48, 50, 52, 54};
        model(ramp, o_nop, mv);
        for (int k = 0; k < VN; k++) check("model_subsample", mv[k], exp1[k]);
        model(ramp, o_avg, mv);
        check("model_avg0", mv[0], 31);
        check("model_avg1", mv[1], 37);
        check("model_avg4", mv[4], 44);
        check("model_avg7", mv[7], 47);
        model(ramp, o_cw, mv);
        check("model_cw0", mv[0], 28);
        check("model_cw1", mv[1], 37);
        model(neg, o_flip, mv);
        check("model_flip0", mv[0], 63);
        check("model_flip1", mv[1], -64);
        check("model_flip15", mv[15], -64);
        model(ramp, o_up, mv);
        check("model_up0", mv[0], 12);
        check("model_up3", mv[3], 15);

        for (int g = 0; g < 2; g++) begin
            run_frame(ramp, o_nop, 1'(g), 1'b1, 1'b0);
            run_frame(ramp, o_avg, 1'(g), 1'b1, 1'b0);
            run_frame(ramp, o_cw, 1'(g), 1'b1, 1'b0);
            run_frame(neg, o_flip, 1'(g), 1'b1, 1'b0);
            run_frame(ramp, o_up, 1'(g), 1'b1, 1'b0);
            run_frame(ramp, o_avg, 1'(g), 1'b0, 1'b1);
            run_frame(ramp, o_nop, 1'(g), 1'b1, 1'b0);
        end

        for (int f = 0; f < 40; f++) begin
            for (int p = 0; p < PIX; p++) rimg[p] = int'($urandom_range(0, 127)) - 64;
            for (int k = 0; k < OPN; k++) rops[k] = int'($urandom_range(0, 15));
            run_frame(rimg, rops, 1'($urandom), 1'b1, 1'b0);
        end

        repeat (5) @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
